// File: rtl/ups_ad2.sv
// Serial ADC front end: free-running SCLK divider, chip-select framing and a 15-edge capture.
// Optional null-bit error flag, enabled by defining UPS_AD2_NULL_CHECK_EN.
`timescale 1ns/1ps
module ups_ad2 #(
  parameter int DIV_BIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        dv,
  output logic [11:0] data,
  output logic        err,
  output logic        busy,
  output logic        sclk,
  input  logic        din,
  output logic        cs_n
);

  // Handshake: start is a level request sampled only in IDLE (ignored, never queued, otherwise);
  // dv is a one-cycle strobe and data/err are valid in that same cycle.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_START = 3'd1,
    SHIFT    = 3'd2,
    CS_STOP  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  div_cnt;
  logic        sclk_l;
  logic        sclk_d;
  logic        sclk_rise;
  logic        sclk_fall;
  logic [3:0]  bit_cnt;
  logic        last_bit;
  logic [14:0] shift_q;
  logic [11:0] data_q;
  logic        unused_bits;

  assign sclk_rise = sclk_l & ~sclk_d;
  assign sclk_fall = ~sclk_l & sclk_d;
  assign last_bit  = (bit_cnt == 4'd14);

  // Discarded bits: upper divider taps and the sample/null positions of the frame.
  assign unused_bits = ^{div_cnt, shift_q[14:12]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 8'd0;
      sclk_l  <= 1'b0;
      sclk_d  <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
      sclk_l  <= div_cnt[DIV_BIT];
      sclk_d  <= sclk_l;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = CS_START;
      CS_START: if (sclk_fall) state_nxt = SHIFT;
      SHIFT:    if (sclk_rise && last_bit) state_nxt = CS_STOP;
      CS_STOP:  if (sclk_fall) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 4'd0;
      shift_q <= 15'd0;
    end else if (state == IDLE && start) begin
      bit_cnt <= 4'd0;
    end else if (state == SHIFT && sclk_rise) begin
      shift_q <= {shift_q[13:0], din};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // The sample lands on the edge that enters DONE, so data is valid alongside dv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 12'd0;
    end else if (state == CS_STOP && sclk_fall) begin
      data_q <= shift_q[11:0];
    end
  end

`ifdef UPS_AD2_NULL_CHECK_EN
  logic null_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      null_q <= 1'b0;
    end else if (state == IDLE && start) begin
      null_q <= 1'b0;
    end else if (state == SHIFT && sclk_rise && bit_cnt == 4'd2) begin
      null_q <= din;
    end
  end
`endif

  // Output logic. The pin uses the delayed copy so its rising edge coincides with the
  // clock edge that captures din, and its falling edge lines up with cs_n going low.
  always_comb begin
    busy = (state != IDLE);
    cs_n = !(state == SHIFT || state == CS_STOP);
    sclk = (state == SHIFT) ? sclk_d : 1'b1;
    dv   = (state == DONE);
`ifdef UPS_AD2_NULL_CHECK_EN
    err  = (state == DONE) & null_q;
`else
    err  = 1'b0;
`endif
  end

  assign data = data_q;

endmodule

// File: tb/tb_ups_ad2.sv
// Bench for ups_ad2: two instances (DIV_BIT=2 and DIV_BIT=0), each with its own ADC model.
// Null-bit expectations follow UPS_AD2_NULL_CHECK_EN.
`timescale 1ns/1ps
module tb_ups_ad2;

`ifdef UPS_AD2_NULL_CHECK_EN
  localparam bit NULL_EN = 1'b1;
`else
  localparam bit NULL_EN = 1'b0;
`endif

  localparam int NV = 8;

  typedef struct {
    logic [11:0] word;
    logic        nul;
    logic [11:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t vecs[NV];
  bit   go = 1'b0;
  bit   done[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic vec_t mk(input logic [11:0] w, input logic n);
    vec_t v;
    v.word     = w;
    v.nul      = n;
    v.exp_data = w;
    v.exp_err  = n & NULL_EN;
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int    DB      = (g == 0) ? 2 : 0;
    localparam int    P       = 1 << (DB + 1);
    localparam int    LAT_MAX = 17 * P + 3;
    localparam int    FRAME   = 18 * P + 8;
    localparam string TAG     = (g == 0) ? "d2" : "d0";

    logic        rst_n;
    logic        start;
    logic        din = 1'b0;
    logic        dv;
    logic        err;
    logic        busy;
    logic        sclk;
    logic        cs_n;
    logic [11:0] data;

    ups_ad2 #(.DIV_BIT(DB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .dv    (dv),
      .data  (data),
      .err   (err),
      .busy  (busy),
      .sclk  (sclk),
      .din   (din),
      .cs_n  (cs_n)
    );

    logic [12:0] exp_q[$];
    logic [14:0] adc_q[$];
    logic [12:0] exp_e;
    logic [14:0] word;
    int  idx;
    bit  seen_rise = 1'b0;
    bit  have_prev = 1'b0;
    int  rises = 0, falls = 0, prev_rise = -1, per_min = 0, per_max = 0;
    int  cyc = 0, dv_cnt = 0, dv_cyc = 0, up_cyc = 0;

    always @(negedge clk) cyc = cyc + 1;

    // ADC model: first bit on cs_n fall, later bits on each sclk fall after a rise.
    always @(negedge cs_n) begin
      word = 15'h0;
      if (adc_q.size() > 0) word = adc_q.pop_front();
      idx = 13; rises = 0; falls = 0; seen_rise = 1'b0;
      prev_rise = -1; per_min = 1 << 20; per_max = 0;
      if (have_prev) check_rng({TAG, ".cs_gap"}, cyc - up_cyc, P / 2, 1 << 20);
      #1 din = word[14];
    end

    always @(posedge cs_n) begin
      seen_rise = 1'b0;
      up_cyc    = cyc;
      have_prev = (rst_n === 1'b1);
    end

    always @(posedge sclk) begin
      if (cs_n === 1'b0) begin
        rises++;
        seen_rise = 1'b1;
        if (prev_rise >= 0) begin
          if (cyc - prev_rise < per_min) per_min = cyc - prev_rise;
          if (cyc - prev_rise > per_max) per_max = cyc - prev_rise;
        end
        prev_rise = cyc;
      end
    end

    always @(negedge sclk) begin
      if (cs_n === 1'b0 && seen_rise) begin
        falls++;
        #1 din = word[idx];
        if (idx > 0) idx--;
      end
    end

    // Scoreboard: every dv pops one expected {data, err}.
    always @(negedge clk) begin
      if (rst_n === 1'b1 && dv === 1'b1) begin
        dv_cnt++;
        dv_cyc = cyc;
        if (exp_q.size() == 0) begin
          check({TAG, ".unexpected_dv"}, 1, 0);
        end else begin
          exp_e = exp_q.pop_front();
          check({TAG, ".data"}, data, exp_e[12:1]);
          check({TAG, ".err"}, err, exp_e[0]);
          check({TAG, ".rises"}, rises, 15);
          check({TAG, ".falls"}, falls, 14);
          check({TAG, ".per_min"}, per_min, P);
          check({TAG, ".per_max"}, per_max, P);
        end
      end
    end

    task automatic wait_dv(input int target);
      int k = 0;
      while (dv_cnt < target && k < FRAME) begin
        @(negedge clk);
        k++;
      end
      check({TAG, ".dv_count"}, dv_cnt, target);
    endtask

    task automatic convert(input vec_t v);
      int t0;
      int tgt;
      adc_q.push_back({2'b00, v.nul, v.word});
      exp_q.push_back({v.exp_data, v.exp_err});
      tgt = dv_cnt + 1;
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      wait_dv(tgt);
      check_rng({TAG, ".latency"}, dv_cyc - t0, 1, LAT_MAX);
      repeat ($urandom_range(1, P + 2)) @(negedge clk);
      check({TAG, ".data_hold"}, data, v.exp_data);
    endtask

    initial begin
      int   k;
      int   n;
      int   tgt;
      vec_t v;
      rst_n = 1'b0;
      start = 1'b0;
      wait (go);
      repeat (3) @(negedge clk);
      check({TAG, ".rst_cs_n"}, cs_n, 1);
      check({TAG, ".rst_sclk"}, sclk, 1);
      check({TAG, ".rst_busy"}, busy, 0);
      check({TAG, ".rst_dv"}, dv, 0);
      check({TAG, ".rst_err"}, err, 0);
      check({TAG, ".rst_data"}, data, 12'h000);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < NV; i++) convert(vecs[i]);

      // Start pulses mid-SHIFT and in the DONE cycle are both dropped.
      adc_q.push_back({3'b000, 12'h5A5});
      exp_q.push_back({12'h5A5, 1'b0});
      tgt = dv_cnt + 1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      k = 0;
      while (cs_n !== 1'b0 && k < FRAME) begin @(negedge clk); k++; end
      repeat (4 * P) @(negedge clk);
      check({TAG, ".busy_shift"}, busy, 1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      k = 0;
      while (dv !== 1'b1 && k < FRAME) begin @(negedge clk); k++; end
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (FRAME) @(negedge clk);
      check({TAG, ".ignored_dv_count"}, dv_cnt, tgt);
      check({TAG, ".idle_busy"}, busy, 0);

      // Start held high: two back-to-back frames.
      adc_q.push_back({3'b000, 12'hFFF});
      adc_q.push_back({3'b000, 12'h000});
      exp_q.push_back({12'hFFF, 1'b0});
      exp_q.push_back({12'h000, 1'b0});
      tgt = dv_cnt + 2;
      @(negedge clk) start = 1'b1;
      k = 0;
      n = 0;
      while (n < 2 && k < 3 * FRAME) begin
        @(negedge clk);
        k++;
        if (dv === 1'b1) n++;
      end
      start = 1'b0;
      repeat (FRAME) @(negedge clk);
      check({TAG, ".b2b_dv_count"}, dv_cnt, tgt);
      check({TAG, ".b2b_data"}, data, 12'h000);

      // Reset at the 8th rising sclk edge aborts the frame with no dv.
      adc_q.push_back({3'b000, 12'hFFF});
      tgt = dv_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      k = 0;
      while (!(cs_n === 1'b0 && rises >= 8) && k < FRAME) begin @(negedge clk); k++; end
      check({TAG, ".abort_rises"}, rises, 8);
      rst_n = 1'b0;
      #1;
      check({TAG, ".abort_cs_n"}, cs_n, 1);
      check({TAG, ".abort_sclk"}, sclk, 1);
      check({TAG, ".abort_busy"}, busy, 0);
      check({TAG, ".abort_data"}, data, 12'h000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (FRAME) @(negedge clk);
      check({TAG, ".abort_dv_count"}, dv_cnt, tgt);
      v = mk(12'h3C3, 1'b0);
      convert(v);

      check({TAG, ".exp_q_empty"}, exp_q.size(), 0);
      done[g] = 1'b1;
    end
  end

  initial begin
    int k;
    vecs[0] = mk(12'hA5C, 1'b0);
    vecs[1] = mk(12'hFFF, 1'b0);
    vecs[2] = mk(12'h000, 1'b0);
    vecs[3] = mk(12'h123, 1'b1);
    vecs[4] = mk(12'h3C3, 1'b0);
    vecs[5] = mk(12'h800, 1'b1);
    vecs[6] = mk(12'h001, 1'b0);
    vecs[7] = mk(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
    go = 1'b1;
    k = 0;
    while (!(done[0] && done[1]) && k < 60000) begin
      @(negedge clk);
      k++;
    end
    if (!(done[0] && done[1])) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got unfinished tests after %0d cycles, expected completion", k);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ups_ad2.md
UPS_AD2 -- requirements
Module: ups_ad2

Interface
REQ-001 The block SHALL have exactly one parameter: DIV_BIT, default 2, divider tap; internal SCLK period = 2^(DIV_BIT+1) clk cycles (8 at default).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 dv  output  1  one-cycle pulse, data valid.
REQ-006 data  output  12  last converted sample, held between dv pulses.
REQ-007 err  output  1  null-bit error qualifier, valid with dv.
REQ-008 busy  output  1  high whenever not in IDLE.
REQ-009 sclk  output  1  ADC serial clock, idles high.
REQ-010 din  input  1  ADC serial data, MSB first.
REQ-011 cs_n  output  1  ADC chip select, active low.

Function
REQ-012 The divider SHALL be a free-running 8-bit counter; internal sclk_l = counter[DIV_BIT], registered; edges SHALL be detected against a one-cycle-delayed copy.
REQ-013 The states SHALL be IDLE, CS_START, SHIFT, CS_STOP, DONE; any other encoding SHALL go to IDLE next cycle.
REQ-014 IDLE: busy=0, cs_n=1, sclk=1; start=1 -> CS_START, bit counter cleared.
REQ-015 CS_START: on the next falling edge of sclk_l, cs_n SHALL go 0 and the state SHALL become SHIFT.
REQ-016 SHIFT: sclk pin SHALL follow sclk_l (registered), cs_n=0; on each rising edge of sclk_l, din SHALL shift into a 15-bit register LSB-in and the counter SHALL increment.
REQ-017 Frame SHALL be 15 rising edges: edges 1-2 sample period (discarded), edge 3 null bit, edges 4-15 data bits 11..0.
REQ-018 After the 15th rising edge, the state SHALL become CS_STOP; sclk pin SHALL return high.
REQ-019 CS_STOP: cs_n held 0 until the next falling edge of sclk_l, then cs_n=1 and state -> DONE.
REQ-020 DONE: data SHALL load shift[11:0], dv SHALL pulse high for exactly one cycle, state -> IDLE.
REQ-021 start while busy=1, including the DONE cycle, SHALL be ignored with no queuing.
REQ-022 start held high continuously SHALL produce back-to-back conversions, with cs_n high for at least one half SCLK period between frames.
REQ-023 start-to-dv latency SHALL not exceed 17 SCLK periods + 3 clk cycles.
REQ-024 data SHALL change only in the DONE cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, divider 0, cs_n=1, sclk=1, dv=0, err=0, busy=0, data=0x000, shift register 0.
REQ-026 Reset mid-frame SHALL abort the frame with no dv; after release, the block SHALL accept start normally.

Configuration
REQ-027 Macro UPS_AD2_NULL_CHECK_EN defined: err SHALL equal the sampled null bit (edge 3) in the DONE cycle and be 0 otherwise; data SHALL still be output.
REQ-028 Macro undefined: err SHALL be constant 0 and no null-bit storage SHALL exist.

Verification
REQ-029 start pulse, ADC model drives null=0, data 0xA5C -> exactly 15 sclk falling/rising pairs while cs_n=0, one dv, data=0xA5C, err=0.
REQ-030 ADC model drives 0xFFF then 0x000 on consecutive starts -> data=0xFFF then 0x000; cs_n high between frames.
REQ-031 start pulsed mid-SHIFT -> ignored; exactly one dv per accepted start.
REQ-032 rst_n low at 8th rising edge -> cs_n=1, sclk=1, busy=0 same cycle; no dv; next start yields correct 0x3C3.
REQ-033 With UPS_AD2_NULL_CHECK_EN, null bit driven 1, data 0x123 -> dv with err=1, data=0x123; without macro -> err=0.
REQ-034 DIV_BIT=0 and DIV_BIT=2 -> sclk period 2 and 8 clk cycles; start-to-dv within REQ-023 bound.
